// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 5;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter wide enough to hold WIDTH itself, so the last-bit index never wraps.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop
// computes {bout, diff} = a - b over WIDTH cycles, LSB first.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_subtractor: WIDTH out of range 2..16");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             bit_d;
  logic             bit_bo;
  logic             accept;
  logic             last_bit;

  full_subtractor u_cell (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bin (br),
    .d   (bit_d),
    .bo  (bit_bo)
  );

  assign accept   = ready & start;
  assign last_bit = (cnt == LAST_BIT);

  // NOTE: every output of this block gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: begin
        ready      = 1'b1;
        done       = 1'b1;
        state_next = start ? ST_SHIFT : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: the operand shift registers are plain flops, not a memory, so they
  // are cleared on reset along with everything else; an aborted operation
  // leaves no stale bits behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      work <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      work <= '0;
      cnt  <= '0;
      br   <= 1'b0;
    end else if (state == ST_SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      work <= {bit_d, work[WIDTH-1:1]};
      br   <= bit_bo;
      cnt  <= cnt + 1'b1;
      // Visible result only changes on the final bit, so diff stays stable
      // for the whole operation and after done drops.
      if (last_bit) begin
        diff <= {bit_d, work[WIDTH-1:1]};
        bout <= bit_bo;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results and
// accept cycles, a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  typedef struct {
    logic [WIDTH:0] res;
    int             acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc           = 0;
  int   n_checks      = 0;
  int   n_pass        = 0;
  int   last_done_cyc = -1;
  logic prev_done     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        check("done_single_cycle", 32'(prev_done), 32'd0);
        check("done_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("result", 32'({bout, diff}), 32'(mon_e.res));
          check("latency", 32'(cyc), 32'(mon_e.acc_cyc + WIDTH));
        end
        last_done_cyc = cyc;
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                       input logic [WIDTH:0] res, input bit push);
    int guard = 0;
    while (!ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_wait", 32'(ready), 32'd1);
    start = 1'b1;
    a     = ai;
    b     = bi;
    @(posedge clk); #1;
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    if (push) sb.push_back('{res: res, acc_cyc: cyc});
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int prev_done_cyc;
    int guard;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_diff",  32'(diff),  32'd0);
    check("rst_bout",  32'(bout),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic: 20 - 7 = 13, then result must hold after done drops.
    issue(5'd20, 5'd7, {1'b0, 5'd13}, 1'b1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("hold_diff", 32'(diff), 32'd13);
    check("hold_bout", 32'(bout), 32'd0);

    // Reset two cycles into an operation: outputs clear at once, no done later.
    issue(5'd20, 5'd7, '0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_done",  32'(done),  32'd0);
    check("midrst_diff",  32'(diff),  32'd0);
    check("midrst_bout",  32'(bout),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (WIDTH + 3) @(posedge clk);
    #1;
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_diff",  32'(diff),  32'd0);

    // Borrow cases.
    issue(5'd3, 5'd9,  {1'b1, 5'd26}, 1'b1);
    issue(5'd0, 5'd31, {1'b1, 5'd1},  1'b1);
    drain();

    // Start pulsed while busy must be ignored.
    issue(5'd10, 5'd4, {1'b0, 5'd6}, 1'b1);
    @(posedge clk); #1;
    check("busy_ready", 32'(ready), 32'd0);
    start = 1'b1;
    a     = 5'd31;
    b     = 5'd31;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
    repeat (WIDTH + 2) @(posedge clk);
    #1;
    check("busy_diff", 32'(diff), 32'd6);
    check("busy_bout", 32'(bout), 32'd0);

    // Back-to-back: start held during DONE is accepted with no dead cycle.
    issue(5'd20, 5'd7, {1'b0, 5'd13}, 1'b1);
    guard = 0;
    while (!done && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("b2b_done_seen", 32'(done), 32'd1);
    prev_done_cyc = cyc;
    start = 1'b1;
    a     = 5'd5;
    b     = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back('{res: {1'b0, 5'd0}, acc_cyc: cyc});
    drain();
    @(negedge clk);
    check("b2b_gap", 32'(last_done_cyc - prev_done_cyc), 32'(WIDTH + 1));

    // Exhaustive sweep of all operand pairs.
    for (int ai = 0; ai < 32; ai++) begin
      for (int bi = 0; bi < 32; bi++) begin
        issue(WIDTH'(ai), WIDTH'(bi), (WIDTH+1)'(ai - bi), 1'b1);
      end
    end
    drain();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
